// File: rtl/ifu_pipe.sv
// ifu_pipe: decoupled fetch unit with credit-limited imem requests, in-order response tracking and an instruction buffer.
module ifu_pipe #(
  parameter int                 XLEN       = 32,
  parameter logic [XLEN-1:0]    RESET_PC   = '0,
  parameter int                 FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            insn_valid_o,
  input  logic            insn_ready_i,
  output logic [31:0]     insn_o,
  output logic [XLEN-1:0] insn_pc_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] LIM = (CW+1)'(FIFO_DEPTH);
  logic [XLEN-1:0] fpc_q, fpc_d, rpc_q, rpc_d, tgt;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [XLEN-1:0] pc_mem_q [FIFO_DEPTH];
  logic [31:0]     insn_mem_q [FIFO_DEPTH];
  logic            req, gnt_ok, push, pop;
  assign tgt    = redirect_pc_i & ~XLEN'(3);
  // credit covers both buffered words and words still owed by memory
  assign req    = rstn_i && !redirect_i && (({1'b0, cnt_q} + {1'b0, out_q}) < LIM);
  assign gnt_ok = req && imem_gnt_i;
  assign push   = imem_rvalid_i && !redirect_i && (disc_q == '0);
  assign pop    = insn_valid_o && insn_ready_i && !redirect_i;
  always_comb begin
    fpc_d  = redirect_i ? tgt : (gnt_ok ? fpc_q + XLEN'(4) : fpc_q);
    rpc_d  = redirect_i ? tgt : (push ? rpc_q + XLEN'(4) : rpc_q);
    out_d  = redirect_i ? out_q - CW'(imem_rvalid_i) : out_q + CW'(gnt_ok) - CW'(imem_rvalid_i);
    disc_d = redirect_i ? out_q - CW'(imem_rvalid_i) :
             ((imem_rvalid_i && disc_q != '0) ? disc_q - CW'(1) : disc_q);
    cnt_d  = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    wptr_d = wptr_q + PW'(push);
    rptr_d = redirect_i ? wptr_q : rptr_q + PW'(pop);
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fpc_q  <= RESET_PC;
      rpc_q  <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        insn_mem_q[i] <= '0;
      end
    end else begin
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push) begin
        pc_mem_q[wptr_q]   <= rpc_q;
        insn_mem_q[wptr_q] <= imem_rdata_i;
      end
    end
  end
  assign imem_req_o   = req;
  assign imem_addr_o  = fpc_q;
  assign insn_valid_o = (cnt_q != '0);
  assign insn_o       = insn_mem_q[rptr_q];
  assign insn_pc_o    = pc_mem_q[rptr_q];
  assert property (@(posedge clk_i) disable iff (!rstn_i) push |-> (cnt_q != CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_ifu_pipe.sv
// tb_ifu_pipe: directed scenarios against a sequential-stream model of the fetch unit with a latency-programmable imem.
module tb_ifu_pipe;
  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        insn_valid_o;
  logic        insn_ready_i = 1'b1;
  logic [31:0] insn_o, insn_pc_o;
  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          cyc = 0;
  int          tests = 0, fails = 0;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  logic [31:0] exp_pc = '0, hold_addr = '0;
  logic        hold_q = 1'b0;

  ifu_pipe #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i),
    .insn_o(insn_o), .insn_pc_o(insn_pc_o)
  );

  always #5 clk = ~clk;
  assign imem_gnt_i = gnt_en && imem_req_o;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    smp();
    while (!insn_valid_o && n < 40) begin
      tick();
      smp();
      n++;
    end
    chk(name, 32'(insn_valid_o), 32'd1);
  endtask

  // memory: in-order responses, each due a programmable number of cycles after its grant
  always @(negedge clk) begin
    if (!rstn_i) mq.delete();
    else begin
      if (imem_rvalid_i && mq.size() > 0) void'(mq.pop_front());
      if (imem_req_o && imem_gnt_i) mq.push_back('{imem_addr_o, cyc + lat});
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      imem_rvalid_i <= 1'b1;
      imem_rdata_i  <= word(mq[0].addr);
    end else begin
      imem_rvalid_i <= 1'b0;
      imem_rdata_i  <= '0;
    end
  end

  // model: the head is always the next PC of the sequential stream since the last reset/redirect
  always @(negedge clk) begin
    if (!rstn_i) begin
      exp_pc = 32'h0;
      hold_q = 1'b0;
    end else begin
      if (hold_q && !redirect_i) begin
        chk("req_hold", 32'(imem_req_o), 32'd1);
        chk("addr_hold", imem_addr_o, hold_addr);
      end
      hold_q    = imem_req_o && !imem_gnt_i;
      hold_addr = imem_addr_o;
      if (insn_valid_o) begin
        chk("head_pc", insn_pc_o, exp_pc);
        chk("head_insn", insn_o, word(exp_pc));
      end
      if (redirect_i) exp_pc = redirect_pc_i & ~32'h3;
      else if (insn_valid_o && insn_ready_i) exp_pc += 32'd4;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad, vcnt, n;
    // reset values and streaming with 1-cycle memory
    tick(); tick(); smp();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(insn_valid_o), 32'd0);
    chk("rst_insn", insn_o, 32'd0);
    chk("rst_pc", insn_pc_o, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    tick(); rstn_i = 1'b1; smp();
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, 32'd0);
    tick(); smp();
    chk("lat_n1_valid", 32'(insn_valid_o), 32'd0);
    tick(); smp();
    chk("lat_n2_valid", 32'(insn_valid_o), 32'd1);
    chk("lat_n2_pc", insn_pc_o, 32'd0);
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      tick(); smp();
      if (!insn_valid_o || insn_pc_o !== 32'(4 * k)) bad++;
    end
    chk("stream_1pc", 32'(bad), 32'd0);
    // IDU stall from reset: buffer fills, credit closes
    tick(); rstn_i = 1'b0; insn_ready_i = 1'b0;
    tick(); tick(); rstn_i = 1'b1;
    repeat (10) tick();
    smp();
    chk("stall_req", 32'(imem_req_o), 32'd0);
    chk("stall_valid", 32'(insn_valid_o), 32'd1);
    chk("stall_owed", 32'(mq.size()), 32'd0);
    chk("stall_head", insn_pc_o, 32'd0);
    tick(); gnt_en = 1'b0; insn_ready_i = 1'b1;
    vcnt = 0;
    repeat (6) begin
      smp();
      if (insn_valid_o) vcnt++;
      tick();
    end
    chk("stall_buffered", 32'(vcnt), 32'd4);
    gnt_en = 1'b1;
    wait_valid("release_timeout");
    chk("release_pc0", insn_pc_o, 32'h10);
    tick(); smp();
    chk("release_pc1", insn_pc_o, 32'h14);
    // 3-cycle memory, redirect with two responses owed
    tick(); rstn_i = 1'b0; gnt_en = 1'b0; lat = 3;
    tick(); tick(); rstn_i = 1'b1; gnt_en = 1'b1;
    tick();
    tick(); gnt_en = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    smp();
    chk("redir_owed", 32'(mq.size()), 32'd2);
    chk("redir_req_low", 32'(imem_req_o), 32'd0);
    tick(); redirect_i = 1'b0; gnt_en = 1'b1;
    smp();
    chk("redir_valid_n1", 32'(insn_valid_o), 32'd0);
    chk("redir_addr_n1", imem_addr_o, 32'h100);
    chk("redir_req_n1", 32'(imem_req_o), 32'd1);
    wait_valid("redir_timeout");
    chk("redir_first_pc", insn_pc_o, 32'h100);
    chk("redir_first_insn", insn_o, word(32'h100));
    // redirect to an unaligned PC coinciding with rvalid and a pop, then a withheld grant
    tick(); lat = 1;
    repeat (8) tick();
    n = 0;
    while (!(imem_rvalid_i && insn_valid_o) && n < 20) begin
      tick();
      n++;
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h203; gnt_en = 1'b0;
    smp();
    chk("coincident", 32'(imem_rvalid_i && insn_valid_o && insn_ready_i), 32'd1);
    tick(); redirect_i = 1'b0;
    smp();
    chk("coinc_empty", 32'(insn_valid_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) smp();
      chk("nogt_req", 32'(imem_req_o), 32'd1);
      chk("nogt_addr", imem_addr_o, 32'h200);
      tick();
    end
    gnt_en = 1'b1;
    smp();
    chk("gnt_addr", imem_addr_o, 32'h200);
    tick(); smp();
    chk("gnt_next_addr", imem_addr_o, 32'h204);
    // two redirects two cycles apart with three responses owed
    tick(); gnt_en = 1'b0;
    n = 0;
    while ((mq.size() != 0 || insn_valid_o) && n < 30) begin
      tick();
      n++;
    end
    chk("drain", 32'(mq.size()) | 32'(insn_valid_o), 32'd0);
    lat = 4; gnt_en = 1'b1;
    tick(); tick();
    tick(); gnt_en = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40;
    smp();
    chk("dbl_owed", 32'(mq.size()), 32'd3);
    tick(); redirect_i = 1'b0; gnt_en = 1'b1;
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h80;
    tick(); redirect_i = 1'b0;
    wait_valid("dbl_timeout");
    chk("dbl_first_pc", insn_pc_o, 32'h80);
    chk("dbl_first_insn", insn_o, word(32'h80));
    tick(); smp();
    chk("dbl_second_pc", insn_pc_o, 32'h84);
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
